// File: rtl/spi_hamming_decoder.sv
// Hamming(7,4) SPI receive decoder: single-error correction plus saturating link counters.
// Two-cycle latency from accept to data_valid pulse; no backpressure, up to one word per cycle.
module spi_hamming_decoder #(
    parameter int CNT_WIDTH = 8,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           code_in,
    input  logic                 code_valid,
    input  logic                 cnt_clr,
    output logic [3:0]           data_out,
    output logic                 data_valid,
    output logic                 err_det,
    output logic [2:0]           err_pos,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic [CNT_WIDTH-1:0] corr_cnt
);

    logic                 vld_hist_q;
    logic                 accept;
    logic [2:0]           syn_d;
    logic [2:0]           syn_q;
    logic [3:0]           raw_q;
    logic                 s1_vld_q;
    logic [3:0]           fix_d;
    logic [3:0]           data_out_q;
    logic                 data_valid_q;
    logic                 err_det_q;
    logic [2:0]           err_pos_q;
    logic [CNT_WIDTH-1:0] word_cnt_q;
    logic [CNT_WIDTH-1:0] word_cnt_d;
    logic [CNT_WIDTH-1:0] corr_cnt_q;
    logic [CNT_WIDTH-1:0] corr_cnt_d;

    // Slave data_valid is a level; only its rising edge marks a new word.
    assign accept = EDGE_MODE ? (code_valid & ~vld_hist_q) : code_valid;

    always_comb begin
        syn_d[0] = code_in[6] ^ code_in[0] ^ code_in[2] ^ code_in[4];
        syn_d[1] = code_in[5] ^ code_in[0] ^ code_in[1] ^ code_in[4];
        syn_d[2] = code_in[3] ^ code_in[1] ^ code_in[2] ^ code_in[0];
    end

    // Parity-bit syndromes (001/010/100) leave the payload untouched.
    always_comb begin
        fix_d = raw_q;
        case (syn_q)
            3'b111:  fix_d = raw_q ^ 4'b0001;
            3'b110:  fix_d = raw_q ^ 4'b0010;
            3'b101:  fix_d = raw_q ^ 4'b0100;
            3'b011:  fix_d = raw_q ^ 4'b1000;
            default: fix_d = raw_q;
        endcase
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        corr_cnt_d = corr_cnt_q;
        if (cnt_clr) begin
            word_cnt_d = '0;
            corr_cnt_d = '0;
        end else if (data_valid_q) begin
            if (word_cnt_q != '1)
                word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
            if (err_det_q && (corr_cnt_q != '1))
                corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_hist_q   <= 1'b0;
            syn_q        <= '0;
            raw_q        <= '0;
            s1_vld_q     <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            err_det_q    <= 1'b0;
            err_pos_q    <= '0;
            word_cnt_q   <= '0;
            corr_cnt_q   <= '0;
        end else begin
            vld_hist_q   <= code_valid;
            s1_vld_q     <= accept;
            if (accept) begin
                syn_q <= syn_d;
                raw_q <= {code_in[4], code_in[2], code_in[1], code_in[0]};
            end
            data_valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                data_out_q <= fix_d;
                err_det_q  <= |syn_q;
                err_pos_q  <= syn_q;
            end
            word_cnt_q <= word_cnt_d;
            corr_cnt_q <= corr_cnt_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign err_det    = err_det_q;
    assign err_pos    = err_pos_q;
    assign word_cnt   = word_cnt_q;
    assign corr_cnt   = corr_cnt_q;

endmodule

// File: tb/tb_spi_hamming_decoder.sv
// Bench for spi_hamming_decoder: a level-accept 8-bit-counter instance and an edge-accept 2-bit-counter instance.
module tb_spi_hamming_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    // Instance A: EDGE_MODE=0, CNT_WIDTH=8
    logic [6:0] a_code_in;
    logic       a_code_valid, a_cnt_clr;
    logic [3:0] a_data_out;
    logic       a_data_valid, a_err_det;
    logic [2:0] a_err_pos;
    logic [7:0] a_word_cnt, a_corr_cnt;

    // Instance B: EDGE_MODE=1, CNT_WIDTH=2
    logic [6:0] b_code_in;
    logic       b_code_valid, b_cnt_clr;
    logic [3:0] b_data_out;
    logic       b_data_valid, b_err_det;
    logic [2:0] b_err_pos;
    logic [1:0] b_word_cnt, b_corr_cnt;

    spi_hamming_decoder #(.CNT_WIDTH(8), .EDGE_MODE(1'b0)) u_lvl (
        .clk(clk), .rst_n(rst_n), .code_in(a_code_in), .code_valid(a_code_valid),
        .cnt_clr(a_cnt_clr), .data_out(a_data_out), .data_valid(a_data_valid),
        .err_det(a_err_det), .err_pos(a_err_pos), .word_cnt(a_word_cnt), .corr_cnt(a_corr_cnt)
    );

    spi_hamming_decoder #(.CNT_WIDTH(2), .EDGE_MODE(1'b1)) u_edg (
        .clk(clk), .rst_n(rst_n), .code_in(b_code_in), .code_valid(b_code_valid),
        .cnt_clr(b_cnt_clr), .data_out(b_data_out), .data_valid(b_data_valid),
        .err_det(b_err_det), .err_pos(b_err_pos), .word_cnt(b_word_cnt), .corr_cnt(b_corr_cnt)
    );

    int checks = 0;
    int passed = 0;

    // Expected entry packing: {data[3:0], err_det, err_pos[2:0]}
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    int a_pulses = 0, a_run = 0, a_maxrun = 0;
    int b_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic p0, p1, p2;
        p0 = d[0] ^ d[2] ^ d[3];
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[1] ^ d[2];
        return {p0, p1, d[3], p2, d[2], d[1], d[0]};
    endfunction

    // Syndrome expected when codeword bit k is flipped; k=7 means no flip.
    function automatic logic [2:0] syn_of(input int k);
        case (k)
            0: return 3'b111;
            1: return 3'b110;
            2: return 3'b101;
            3: return 3'b100;
            4: return 3'b011;
            5: return 3'b010;
            6: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [7:0] e;
        if (a_data_valid) begin
            a_pulses++;
            a_run++;
            if (a_run > a_maxrun) a_maxrun = a_run;
            chk("a_expected_pending", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_data_out", 32'(a_data_out), 32'(e[7:4]));
                chk("a_err_det", 32'(a_err_det), 32'(e[3]));
                chk("a_err_pos", 32'(a_err_pos), 32'(e[2:0]));
            end
        end else begin
            a_run = 0;
        end
        if (b_data_valid) begin
            b_pulses++;
            chk("b_expected_pending", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_data_out", 32'(b_data_out), 32'(e[7:4]));
                chk("b_err_det", 32'(b_err_det), 32'(e[3]));
                chk("b_err_pos", 32'(b_err_pos), 32'(e[2:0]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [6:0] code, input logic [3:0] d, input logic [2:0] syn);
        a_code_in    = code;
        a_code_valid = 1'b1;
        qa.push_back({d, (syn != 3'b000), syn});
        step(1);
    endtask

    initial begin
        logic [6:0] cw;
        rst_n = 1'b0;
        a_code_in = '0; a_code_valid = 1'b0; a_cnt_clr = 1'b0;
        b_code_in = '0; b_code_valid = 1'b0; b_cnt_clr = 1'b0;
        step(3);

        chk("rst_data_out", 32'(a_data_out), 32'h0);
        chk("rst_data_valid", 32'(a_data_valid), 32'h0);
        chk("rst_err_det", 32'(a_err_det), 32'h0);
        chk("rst_err_pos", 32'(a_err_pos), 32'h0);
        chk("rst_word_cnt", 32'(a_word_cnt), 32'h0);
        chk("rst_corr_cnt", 32'(a_corr_cnt), 32'h0);
        chk("rst_b_word_cnt", 32'(b_word_cnt), 32'h0);
        rst_n = 1'b1;
        step(2);

        // Clean word 0x33 with exact latency
        send_a(7'h33, 4'hB, 3'b000);
        a_code_valid = 1'b0;
        chk("lat_t0_valid", 32'(a_data_valid), 32'h0);
        step(1);
        chk("lat_t1_valid", 32'(a_data_valid), 32'h1);
        step(1);
        chk("lat_t2_valid", 32'(a_data_valid), 32'h0);
        chk("first_word_cnt", 32'(a_word_cnt), 32'h1);
        chk("first_corr_cnt", 32'(a_corr_cnt), 32'h0);

        // d0 flipped, outputs hold afterwards
        send_a(7'h32, 4'hB, 3'b111);
        a_code_valid = 1'b0;
        step(3);
        chk("hold_err_det", 32'(a_err_det), 32'h1);
        chk("hold_err_pos", 32'(a_err_pos), 32'h7);
        chk("hold_data_out", 32'(a_data_out), 32'hB);
        chk("d0_word_cnt", 32'(a_word_cnt), 32'h2);
        chk("d0_corr_cnt", 32'(a_corr_cnt), 32'h1);

        // All payloads x every single-bit flip, back to back
        for (int d = 0; d < 16; d++) begin
            for (int k = 0; k < 8; k++) begin
                cw = enc(4'(d));
                if (k < 7) cw = cw ^ (7'd1 << k);
                send_a(cw, 4'(d), syn_of(k));
            end
        end
        a_code_valid = 1'b0;
        step(3);
        chk("sweep_word_cnt", 32'(a_word_cnt), 32'd130);
        chk("sweep_corr_cnt", 32'(a_corr_cnt), 32'd113);

        // Double error aliases to p0 and is miscorrected
        send_a(7'h30, 4'h8, 3'b001);
        a_code_valid = 1'b0;
        step(3);
        chk("dbl_corr_cnt", 32'(a_corr_cnt), 32'd114);

        // Level held 5 cycles on both instances
        a_pulses = 0; a_maxrun = 0; b_pulses = 0;
        b_code_in = 7'h7F;
        b_code_valid = 1'b1;
        qb.push_back({4'hF, 1'b0, 3'b000});
        for (int i = 0; i < 5; i++) send_a(7'h7F, 4'hF, 3'b000);
        a_code_valid = 1'b0;
        b_code_valid = 1'b0;
        step(4);
        chk("lvl_pulses", 32'(a_pulses), 32'd5);
        chk("lvl_consecutive", 32'(a_maxrun), 32'd5);
        chk("edge_pulses", 32'(b_pulses), 32'd1);

        // cnt_clr coincident with data_valid and with a fresh accept
        send_a(7'h33, 4'hB, 3'b000);
        a_code_valid = 1'b0;
        step(1);
        chk("clr_vld_present", 32'(a_data_valid), 32'h1);
        a_cnt_clr = 1'b1;
        send_a(7'h32, 4'hB, 3'b111);
        a_cnt_clr = 1'b0;
        a_code_valid = 1'b0;
        chk("clr_word_cnt", 32'(a_word_cnt), 32'h0);
        chk("clr_corr_cnt", 32'(a_corr_cnt), 32'h0);
        step(3);
        chk("post_clr_word_cnt", 32'(a_word_cnt), 32'h1);
        chk("post_clr_corr_cnt", 32'(a_corr_cnt), 32'h1);

        // Two-bit counters saturate
        b_cnt_clr = 1'b1;
        step(1);
        b_cnt_clr = 1'b0;
        chk("b_clr_word_cnt", 32'(b_word_cnt), 32'h0);
        b_code_in = 7'h32;
        for (int i = 0; i < 5; i++) begin
            b_code_valid = 1'b1;
            qb.push_back({4'hB, 1'b1, 3'b111});
            step(1);
            b_code_valid = 1'b0;
            step(1);
        end
        step(3);
        chk("sat_word_cnt", 32'(b_word_cnt), 32'h3);
        chk("sat_corr_cnt", 32'(b_corr_cnt), 32'h3);

        // Reset one cycle after accept discards the word
        a_pulses = 0;
        a_code_in = 7'h7F;
        a_code_valid = 1'b1;
        step(1);
        a_code_valid = 1'b0;
        rst_n = 1'b0;
        step(2);
        chk("mid_rst_data_out", 32'(a_data_out), 32'h0);
        chk("mid_rst_err_det", 32'(a_err_det), 32'h0);
        chk("mid_rst_err_pos", 32'(a_err_pos), 32'h0);
        chk("mid_rst_word_cnt", 32'(a_word_cnt), 32'h0);
        rst_n = 1'b1;
        step(4);
        chk("mid_rst_no_valid", 32'(a_pulses), 32'd0);

        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
